mips_state_dumper: RTL and testbench

Debug readout engine for the pipelined KGP-RISC core. On a start pulse it asks the core to freeze, then reads every register-file entry and a configurable window of data memory through dedicated read ports. It serialises them as a framed byte stream over a valid/ready interface, so a host, UART bridge or bench sink can capture architectural state without peeking at internal arrays. It sits beside the core, on the read side of the register bank and data memory.

---
 rtl/mips_state_dumper.sv | 89 ++++++++
 tb/tb_mips_state_dumper.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_state_dumper.sv
// mips_state_dumper: freezes the core and streams the register file plus a memory window as a checksummed byte frame
module mips_state_dumper #(
   parameter int NREGS = 32,
   parameter int DMEM_AW = 10,
   parameter int DMEM_BASE = 0,
   parameter int DMEM_COUNT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic halt_req,
   input  logic halted,
   output logic [4:0] rf_raddr,
   input  logic [31:0] rf_rdata,
   output logic dm_re,
   output logic [DMEM_AW-1:0] dm_raddr,
   input  logic [31:0] dm_rdata,
   output logic [7:0] tx_data,
   output logic tx_valid,
   input  logic tx_ready,
   output logic busy,
   output logic done
);
   localparam int TOTAL = NREGS + DMEM_COUNT;
   localparam int WW = $clog2(TOTAL + 1);
   typedef enum logic [2:0] {IDLE, HALT_WAIT, HDR, RD_ADDR, RD_CAP, SEND, CKSUM} state_t;
   state_t state, state_nxt;
   logic [WW-1:0] word, word_nxt;
   logic [1:0] byte_idx;
   logic [31:0] shreg;
   logic [7:0] cksum;
   logic accept, is_mem;
   assign accept = tx_valid && tx_ready;
   assign is_mem = word >= WW'(NREGS);
   assign halt_req = state != IDLE;
   assign busy = state != IDLE;
   assign tx_valid = state == HDR || state == SEND || state == CKSUM;
   assign tx_data = state == HDR ? 8'hA5 : state == SEND ? shreg[31:24] : state == CKSUM ? cksum : 8'h00;
   assign dm_re = state == RD_ADDR && is_mem;
   // next state and word index; a start arriving with done is dropped so frames never chain
   always_comb begin
      state_nxt = state;
      word_nxt = word;
      case (state)
         IDLE:      if (start && !done) state_nxt = HALT_WAIT;
         HALT_WAIT: if (halted) state_nxt = HDR;
         HDR:       if (accept) state_nxt = RD_ADDR;
         RD_ADDR:   state_nxt = RD_CAP;
         RD_CAP:    state_nxt = SEND;
         SEND: if (accept && byte_idx == 2'd3) begin
            word_nxt = word + WW'(1);
            state_nxt = word_nxt == WW'(TOTAL) ? CKSUM : RD_ADDR;
         end
         CKSUM:     if (accept) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end
   // state, read addresses (updated only on entry to RD_ADDR so they hold otherwise), word shifter and checksum
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         word <= '0;
         byte_idx <= '0;
         shreg <= '0;
         cksum <= '0;
         done <= 1'b0;
         rf_raddr <= '0;
         dm_raddr <= '0;
      end else begin
         state <= state_nxt;
         word <= state == IDLE ? '0 : word_nxt;
         done <= state == CKSUM && accept;
         if (state == IDLE) begin
            cksum <= '0;
            byte_idx <= '0;
         end
         if (state_nxt == RD_ADDR) begin
            if (word_nxt < WW'(NREGS)) rf_raddr <= 5'(word_nxt);
            else dm_raddr <= DMEM_AW'(DMEM_BASE + int'(word_nxt) - NREGS);
         end
         if (state == RD_CAP) shreg <= is_mem ? dm_rdata : rf_rdata;
         if (state == SEND && accept) begin
            shreg <= shreg << 8;
            byte_idx <= byte_idx + 2'd1;
            cksum <= cksum + shreg[31:24];
         end
      end
   end
endmodule

// File: tb/tb_mips_state_dumper.sv
// tb_mips_state_dumper: scoreboard bench driving random data and back-pressure against a frame-level model
module tb_mips_state_dumper;
   logic clk = 1'b0;
   logic reset = 1'b1, start = 1'b0, w_start = 1'b0, hold_low = 1'b0, rand_ready = 1'b0, tx_ready = 1'b1;
   logic halt_req, halted, dm_re, tx_valid, busy, done;
   logic [4:0] rf_raddr;
   logic [9:0] dm_raddr;
   logic [31:0] rf_rdata, dm_rdata;
   logic [7:0] tx_data;
   logic w_halt_req, w_halted, w_dm_re, w_tx_valid, w_busy, w_done;
   logic [4:0] w_rf_raddr;
   logic [9:0] w_dm_raddr;
   logic [31:0] w_rf_rdata, w_dm_rdata;
   logic [7:0] w_tx_data;
   logic [1:0] hd = 2'b00, w_hd = 2'b00;
   logic [31:0] rf [32];
   logic [31:0] dm [1024];
   logic [7:0] exp_q[$], w_q[$], frame[$];
   logic [9:0] w_addr_q[$];
   int tests = 0, fails = 0, nbytes = 0, ndone = 0, w_nbytes = 0, w_ndone = 0;
   logic stalled = 1'b0;
   logic [7:0] held = 8'h00;

   always #5 clk = ~clk;

   mips_state_dumper dut (
      .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .halted(halted),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dm_re(dm_re), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
   );

   mips_state_dumper #(.NREGS(32), .DMEM_AW(10), .DMEM_BASE(1020), .DMEM_COUNT(8)) u_wrap (
      .clk(clk), .reset(reset), .start(w_start), .halt_req(w_halt_req), .halted(w_halted),
      .rf_raddr(w_rf_raddr), .rf_rdata(w_rf_rdata), .dm_re(w_dm_re), .dm_raddr(w_dm_raddr), .dm_rdata(w_dm_rdata),
      .tx_data(w_tx_data), .tx_valid(w_tx_valid), .tx_ready(1'b1), .busy(w_busy), .done(w_done)
   );

   // synchronous-read memories and a core that acknowledges halt two cycles late
   always @(posedge clk) begin
      rf_rdata <= rf[rf_raddr];
      if (dm_re) dm_rdata <= dm[dm_raddr];
      hd <= {hd[0], halt_req};
      w_rf_rdata <= rf[w_rf_raddr];
      if (w_dm_re) w_dm_rdata <= dm[w_dm_raddr];
      w_hd <= {w_hd[0], w_halt_req};
   end
   assign halted = hold_low ? 1'b0 : hd[1];
   assign w_halted = w_hd[1];

   initial forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // frame as the host should see it: header, words MSB first, sum of word bytes
   function automatic void build_frame(input int nregs, input int base, input int count, input int aw);
      logic [31:0] w;
      logic [7:0] sum;
      frame.delete();
      sum = 8'h00;
      frame.push_back(8'hA5);
      for (int i = 0; i < nregs + count; i++) begin
         w = i < nregs ? rf[i] : dm[(base + i - nregs) % (1 << aw)];
         for (int b = 3; b >= 0; b--) begin
            frame.push_back(w[8*b +: 8]);
            sum += w[8*b +: 8];
         end
      end
      frame.push_back(sum);
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (stalled) check("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held});
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) check("extra_byte", {24'd0, tx_data}, 32'h100);
            else check($sformatf("byte%0d", nbytes), {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            nbytes++;
         end
         if (done) ndone++;
         stalled = tx_valid && !tx_ready;
         held = tx_data;
         if (w_tx_valid) begin
            if (w_q.size() == 0) check("w_extra_byte", {24'd0, w_tx_data}, 32'h100);
            else check($sformatf("w_byte%0d", w_nbytes), {24'd0, w_tx_data}, {24'd0, w_q.pop_front()});
            w_nbytes++;
         end
         if (w_dm_re) begin
            if (w_addr_q.size() == 0) check("w_extra_addr", {22'd0, w_dm_raddr}, 32'hFFFF);
            else check("w_addr", {22'd0, w_dm_raddr}, {22'd0, w_addr_q.pop_front()});
         end
         if (w_done) w_ndone++;
      end else stalled = 1'b0;
   end

   task automatic wait_count(input bit wrap, input bit on_done, input int target, input int budget);
      int n = 0;
      int cur;
      cur = on_done ? (wrap ? w_ndone : ndone) : (wrap ? w_nbytes : nbytes);
      while (cur < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
         cur = on_done ? (wrap ? w_ndone : ndone) : (wrap ? w_nbytes : nbytes);
      end
      if (cur < target) check("wait_timeout", cur, target);
   endtask

   task automatic pulse(input bit wrap);
      @(posedge clk);
      #1;
      if (wrap) w_start = 1'b1;
      else start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      w_start = 1'b0;
   endtask

   task automatic load_frame();
      build_frame(32, 0, 16, 10);
      foreach (frame[i]) exp_q.push_back(frame[i]);
   endtask

   task automatic randomize_data();
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      for (int i = 0; i < 16; i++) dm[i] = $urandom;
   endtask

   task automatic run_full(input string tag);
      int base, d0;
      load_frame();
      base = nbytes;
      d0 = ndone;
      pulse(1'b0);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_halt_req"}, halt_req, 1);
      wait_count(1'b0, 1'b1, d0 + 1, 3000);
      check({tag, "_len"}, nbytes - base, 194);
      check({tag, "_queue"}, exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_one_done"}, ndone - d0, 1);
   endtask

   initial begin
      int base, d0;
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      for (int i = 0; i < 1024; i++) dm[i] = 32'd0;
      rf[1] = 32'd5;
      rf[2] = 32'h12345678;
      dm[0] = 32'hDEADBEEF;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_halt_req", halt_req, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dm_re", dm_re, 0);
      check("rst_rf_raddr", rf_raddr, 0);
      check("rst_dm_raddr", dm_raddr, 0);
      reset = 1'b0;
      run_full("plain");
      rand_ready = 1'b1;
      run_full("stall");
      randomize_data();
      load_frame();
      base = nbytes;
      d0 = ndone;
      pulse(1'b0);
      wait_count(1'b0, 1'b0, base + 20, 2000);
      pulse(1'b0);
      wait_count(1'b0, 1'b0, base + 194, 4000);
      @(posedge clk);
      #1;
      check("done_at_end", done, 1);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_low_after_done", busy, 0);
      check("halt_low_after_done", halt_req, 0);
      repeat (20) @(posedge clk);
      #1;
      check("no_restart", busy, 0);
      check("restart_one_done", ndone - d0, 1);
      check("restart_len", nbytes - base, 194);
      randomize_data();
      load_frame();
      base = nbytes;
      d0 = ndone;
      pulse(1'b0);
      wait_count(1'b0, 1'b0, base + 50, 2000);
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      check("midrst_tx_valid", tx_valid, 0);
      check("midrst_halt_req", halt_req, 0);
      check("midrst_busy", busy, 0);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("midrst_no_done", ndone - d0, 0);
      run_full("after_rst");
      rand_ready = 1'b0;
      hold_low = 1'b1;
      load_frame();
      base = nbytes;
      d0 = ndone;
      pulse(1'b0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         check("halt_wait", {halt_req, busy, tx_valid}, 3'b110);
      end
      @(posedge clk);
      #1;
      hold_low = 1'b0;
      @(posedge clk);
      #1;
      check("hdr_valid", tx_valid, 1);
      check("hdr_data", tx_data, 8'hA5);
      wait_count(1'b0, 1'b1, d0 + 1, 3000);
      check("halt_len", nbytes - base, 194);
      for (int i = 1016; i < 1024; i++) dm[i] = $urandom;
      for (int i = 0; i < 8; i++) dm[i] = $urandom;
      build_frame(32, 1020, 8, 10);
      foreach (frame[i]) w_q.push_back(frame[i]);
      for (int i = 0; i < 8; i++) w_addr_q.push_back(10'((1020 + i) % 1024));
      base = w_nbytes;
      d0 = w_ndone;
      pulse(1'b1);
      wait_count(1'b1, 1'b1, d0 + 1, 3000);
      check("wrap_len", w_nbytes - base, 162);
      check("wrap_queue", w_q.size(), 0);
      check("wrap_addr_queue", w_addr_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
